pipe_hazard_ctrl: RTL and testbench

Central pipeline-control unit for the five-stage Y86-64 pipeline. It generates the stall and bubble strobes for the F, D, E, M and W pipeline registers, and gates condition-code updates. It also sequences the pipeline through a post-reset flush, a debug freeze/single-step mode and a terminal halt on exception. It sits beside the stage registers; their stall/bubble inputs connect only to this block.

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble strobes, CC-write gating, boot/freeze/halt sequencing.
// Latency: strobes combinational from inputs and state; state, halt_status, counters register on clock.
// Backpressure: none; the stage registers obey the strobes directly. Optional PIPE_PERF_CNT_EN adds counters.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_cnd,
  input  logic [1:0]       m_status,
  input  logic [1:0]       W_status,
  input  logic             dbg_freeze,
  input  logic             dbg_step,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       cpu_state,
  output logic [1:0]       halt_status
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [1:0] halt_status_q, halt_status_d;

  logic lu, rt, mp, exc, w_exc, step_cyc, run_cyc;

  // Hazard detection shared by RUN and single-step cycles
  always_comb begin
    lu = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mp = (E_icode == 4'h7) && !e_cnd;
    w_exc = (W_status != 2'd0);
    exc = (m_status != 2'd0) || w_exc;
    step_cyc = (state_q == ST_FROZEN) && dbg_step;
    run_cyc  = (state_q == ST_RUN) || step_cyc;
  end

  // Strobe selection: RUN equations in RUN or step cycles, fixed patterns otherwise
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    if (state_q == ST_BOOT) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (run_cyc) begin
      F_stall  = lu | rt;
      D_stall  = lu;
      W_stall  = w_exc;
      D_bubble = mp | (rt & !lu);
      E_bubble = mp | lu;
      M_bubble = exc;
      set_cc   = (E_icode == 4'h6) && !exc;
    end else begin
      // Frozen without a step, or halted: hold every stage
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end
  end

  // Next-state: boot countdown, halt has priority over freeze, step-gated halt while frozen
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    halt_status_d = halt_status_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
        else boot_cnt_d = boot_cnt_q + 4'd1;
      end
      ST_RUN: begin
        if (w_exc) begin
          state_d       = ST_HALTED;
          halt_status_d = W_status;
        end else if (dbg_freeze) begin
          state_d = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (dbg_step && w_exc) begin
          state_d       = ST_HALTED;
          halt_status_d = W_status;
        end else if (!dbg_freeze) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // Control FSM registers; reset always returns to BOOT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= 4'd0;
      halt_status_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      halt_status_q <= halt_status_d;
    end
  end

  assign cpu_state   = state_q;
  assign halt_status = halt_status_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_cycles_q, bubble_cycles_d;

  // Saturating event counters, active only in RUN or step cycles
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    bubble_cycles_d = bubble_cycles_q;
    if (run_cyc && F_stall && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (run_cyc && (D_bubble | E_bubble) && (bubble_cycles_q != '1))
      bubble_cycles_d = bubble_cycles_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q  <= '0;
      bubble_cycles_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps plus random traffic against a behavioural model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Honours PIPE_PERF_CNT_EN when defined (counter ports and checks).
module tb_pipe_hazard_ctrl;
  localparam int BOOT = 4;
  localparam int CW   = 4;

  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic e_cnd;
  logic [1:0] m_status, W_status;
  logic dbg_freeze, dbg_step;
  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, set_cc;
  logic [1:0] cpu_state, halt_status;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, bubble_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int eb_seen = 0;

  // behavioural model state: 0 BOOT, 1 RUN, 2 FROZEN, 3 HALTED
  int m_st = 0;
  int m_boot = 0;
  int m_halt = 0;
  int m_scnt = 0;
  int m_bcnt = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
    .m_status(m_status), .W_status(W_status),
    .dbg_freeze(dbg_freeze), .dbg_step(dbg_step),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .set_cc(set_cc),
    .cpu_state(cpu_state), .halt_status(halt_status)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobe vector {F,D,E,M,W stall, D,E,M bubble, set_cc} from the hazard rules
  function automatic logic [8:0] expect_strobes(int st, bit step);
    bit load_in_e, lu, rt, mp, exc, w_bad;
    load_in_e = (E_icode == 5) || (E_icode == 11);
    lu = load_in_e && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = (D_icode == 9) || (E_icode == 9) || (M_icode == 9);
    mp = (E_icode == 7) && (e_cnd == 0);
    w_bad = (W_status != 0);
    exc = (m_status != 0) || w_bad;
    if (st == 0) return 9'b00000_111_0;
    if (st == 1 || (st == 2 && step))
      return {lu | rt, lu, 1'b0, 1'b0, w_bad, mp | (rt & !lu), mp | lu, exc, (E_icode == 6) && !exc};
    return 9'b11111_000_0;
  endfunction

  function automatic logic [8:0] observed_strobes();
    return {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};
  endfunction

  // Check one cycle on the falling edge, then advance the model over the rising edge
  task automatic cycle(input string tag);
    logic [8:0] e;
    bit counts;
    int lim;
    @(negedge clock);
    e = expect_strobes(m_st, dbg_step);
    chk({tag, "_strobes"}, 64'(observed_strobes()), 64'(e));
    chk({tag, "_state"}, 64'(cpu_state), 64'(m_st));
    chk({tag, "_halt"}, 64'(halt_status), 64'(m_halt));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, "_scnt"}, 64'(stall_cycles), 64'(m_scnt));
    chk({tag, "_bcnt"}, 64'(bubble_cycles), 64'(m_bcnt));
`endif
    eb_seen += int'(E_bubble);
    counts = (m_st == 1) || (m_st == 2 && dbg_step);
    lim = (1 << CW) - 1;
    if (counts && e[8] && m_scnt < lim) m_scnt++;
    if (counts && (e[3] || e[2]) && m_bcnt < lim) m_bcnt++;
    case (m_st)
      0: begin m_boot++; if (m_boot >= BOOT) m_st = 1; end
      1: if (W_status != 0) begin m_st = 3; m_halt = W_status; end
         else if (dbg_freeze) m_st = 2;
      2: if (dbg_step && W_status != 0) begin m_st = 3; m_halt = W_status; end
         else if (!dbg_freeze) m_st = 1;
      default: m_st = 3;
    endcase
    @(posedge clock);
    #1;
  endtask

  task automatic nop_inputs();
    D_icode = 1; E_icode = 1; M_icode = 1; E_dstM = 15; d_srcA = 15; d_srcB = 15;
    e_cnd = 1; m_status = 0; W_status = 0; dbg_freeze = 0; dbg_step = 0;
  endtask

  // Asynchronous reset pulse issued mid-cycle; released just after the next rising edge
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_async_state", 64'(cpu_state), 64'd0);
    chk("rst_async_strobes", 64'(observed_strobes()), 64'(9'b00000_111_0));
    m_st = 0; m_boot = 0; m_halt = 0; m_scnt = 0; m_bcnt = 0;
    @(posedge clock);
    #1;
    chk("rst_hold_state", 64'(cpu_state), 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int halted_for;
    nop_inputs();
    reset_n = 1'b0;
    #2;
    chk("por_state", 64'(cpu_state), 64'd0);
    chk("por_halt", 64'(halt_status), 64'd0);
    chk("por_strobes", 64'(observed_strobes()), 64'(9'b00000_111_0));
    @(posedge clock); #1;
    reset_n = 1'b1;

    // boot sequence then idle RUN
    for (int i = 0; i < BOOT; i++) cycle("boot");
    chk("boot_done_state", 64'(cpu_state), 64'd1);
    cycle("run_nop");

    // load/use, then same with no destination
    E_icode = 5; E_dstM = 3; d_srcA = 3;
    cycle("lu");
    E_dstM = 15;
    cycle("lu_none");
    E_icode = 11; E_dstM = 4; d_srcA = 15; d_srcB = 4;
    cycle("lu_pop_srcb");

    // mispredict, alone and with ret in decode
    nop_inputs(); E_icode = 7; e_cnd = 0;
    cycle("mp");
    D_icode = 9;
    cycle("mp_ret");
    nop_inputs(); M_icode = 9; E_icode = 5; E_dstM = 2; d_srcB = 2;
    cycle("ret_lu");

    // CC gating around exceptions, then halt
    nop_inputs(); E_icode = 6;
    cycle("opq");
    m_status = 2;
    cycle("opq_exc");
    m_status = 0; W_status = 2;
    cycle("w_exc");
    chk("halted_state", 64'(cpu_state), 64'd3);
    chk("halted_status", 64'(halt_status), 64'd2);
    W_status = 1; dbg_freeze = 1;
    for (int i = 0; i < 3; i++) cycle("halted");
    nop_inputs();
    do_reset();
    for (int i = 0; i < BOOT + 1; i++) cycle("reboot");

    // freeze with three single steps under a load/use hazard
    E_icode = 5; E_dstM = 3; d_srcA = 3;
    dbg_step = 1;
    cycle("step_in_run");
    dbg_step = 0; dbg_freeze = 1;
    cycle("freeze_sample");
    eb_seen = 0;
    cycle("frozen");
    cycle("frozen");
    for (int i = 0; i < 3; i++) begin
      dbg_step = 1; cycle("step");
      dbg_step = 0; cycle("frozen_gap");
    end
    chk("step_count", 64'(eb_seen), 64'd3);
    dbg_freeze = 0;
    cycle("unfreeze");
    cycle("run_after_freeze");

    // halt beats freeze; frozen halt only through a step
    nop_inputs(); dbg_freeze = 1;
    cycle("freeze_again");
    W_status = 3;
    cycle("frozen_w_nostep");
    dbg_step = 1;
    cycle("frozen_w_step");
    chk("step_halt_status", 64'(halt_status), 64'd3);
    nop_inputs();
    do_reset();
    dbg_freeze = 1; W_status = 2;
    for (int i = 0; i < BOOT; i++) cycle("boot_ignores");
    cycle("halt_over_freeze");
    chk("hof_state", 64'(cpu_state), 64'd3);

`ifdef PIPE_PERF_CNT_EN
    nop_inputs();
    do_reset();
    for (int i = 0; i < BOOT; i++) cycle("pc_boot");
    E_icode = 5; E_dstM = 3; d_srcA = 3;
    for (int i = 0; i < 5; i++) cycle("pc_lu");
    chk("pc_stall5", 64'(stall_cycles), 64'd5);
    chk("pc_bubble5", 64'(bubble_cycles), 64'd5);
    for (int i = 0; i < 15; i++) cycle("pc_sat");
    chk("pc_stall_sat", 64'(stall_cycles), 64'((1 << CW) - 1));
    chk("pc_bubble_sat", 64'(bubble_cycles), 64'((1 << CW) - 1));
`endif

    // random traffic against the model
    nop_inputs();
    do_reset();
    halted_for = 0;
    for (int n = 0; n < 400; n++) begin
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      E_dstM = 4'($urandom_range(0, 15));
      d_srcA = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
      d_srcB = 4'($urandom_range(0, 15));
      e_cnd = 1'($urandom_range(0, 1));
      m_status = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_status = ($urandom_range(0, 30) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 9) == 0) dbg_freeze = ~dbg_freeze;
      dbg_step = ($urandom_range(0, 2) == 0);
      cycle("rnd");
      halted_for = (m_st == 3) ? halted_for + 1 : 0;
      if (halted_for > 3 || $urandom_range(0, 80) == 0) begin
        do_reset();
        halted_for = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
